// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared widths, weight vector type and FSM states for the output-layer scorer
package nn_pkg;

    localparam int N_CLASS = 10;
    localparam int ACT_W   = 8;
    localparam int W_W     = 8;
    localparam int PROD_W  = 17;
    localparam int SCORE_W = 26;

    // Ten signed weights; class k lives in element k, i.e. bits [8k+7:8k].
    typedef logic signed [N_CLASS-1:0][W_W-1:0] w_vec_t;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // max_selector compares unsigned, so negative totals become zero.
    function automatic logic [SCORE_W-1:0] clamp_score(input logic signed [SCORE_W-1:0] acc);
        return acc[SCORE_W-1] ? '0 : acc;
    endfunction

endpackage

// File: rtl/output_score_accum_if.sv
// rtl/output_score_accum_if.sv - activation/weight beat stream into the scorer
interface output_score_accum_if;
    import nn_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [ACT_W-1:0]   in_act;
    w_vec_t             in_w;
    logic               in_last;

    modport master (output in_valid, output in_act, output in_w, output in_last, input in_ready);
    modport slave  (input in_valid, input in_act, input in_w, input in_last, output in_ready);

endinterface

// File: rtl/score_mac.sv
// rtl/score_mac.sv - one class lane: product register, accumulator, clamped score register
module score_mac
    import nn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_en,
    input  logic [ACT_W-1:0]        act,
    input  logic signed [W_W-1:0]   w,
    input  logic                    acc_en,
    input  logic                    first,
    input  logic                    out_en,
    output logic [SCORE_W-1:0]      score
);

    logic signed [PROD_W-1:0]  act_s;
    logic signed [PROD_W-1:0]  w_s;
    logic signed [PROD_W-1:0]  prod_c;
    logic signed [PROD_W-1:0]  prod_q;
    logic signed [SCORE_W-1:0] prod_ext;
    logic signed [SCORE_W-1:0] acc_q;

    // Activation is unsigned, weight signed; the true product always fits 17 signed bits.
    assign act_s    = {{(PROD_W-ACT_W){1'b0}}, act};
    assign w_s      = {{(PROD_W-W_W){w[W_W-1]}}, w};
    assign prod_c   = act_s * w_s;
    assign prod_ext = {{(SCORE_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

    // Stage 1: capture the product of an accepted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            prod_q <= '0;
        else if (ld_en)
            prod_q <= prod_c;
    end

    // Stage 2: first beat of a frame loads, later beats add.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc_q <= '0;
        else if (acc_en)
            acc_q <= first ? prod_ext : acc_q + prod_ext;
    end

    // Stage 3: publish the clamped total only for a good frame; held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            score <= '0;
        else if (out_en)
            score <= clamp_score(acc_q);
    end

endmodule

// File: rtl/output_score_accum.sv
// rtl/output_score_accum.sv - ten-class dot-product scorer with frame length checking
module output_score_accum
    import nn_pkg::*;
#(
    parameter int N_IN = 784
) (
    input  logic                clk,
    input  logic                rst,
    output_score_accum_if.slave in_if,
    output logic [SCORE_W-1:0]  s0,
    output logic [SCORE_W-1:0]  s1,
    output logic [SCORE_W-1:0]  s2,
    output logic [SCORE_W-1:0]  s3,
    output logic [SCORE_W-1:0]  s4,
    output logic [SCORE_W-1:0]  s5,
    output logic [SCORE_W-1:0]  s6,
    output logic [SCORE_W-1:0]  s7,
    output logic [SCORE_W-1:0]  s8,
    output logic [SCORE_W-1:0]  s9,
    output logic                Input_Valid,
    output logic                frame_err
);

    localparam int              CNT_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(N_IN - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q;
    logic               drop_q;
    logic               fire;
    logic               at_end;
    logic               first_c;
    logic               take;
    logic               good_c;
    logic               err_c;

    logic               v1_q, first1_q, good1_q, err1_q;
    logic               good2_q, err2_q;

    logic [SCORE_W-1:0] score [N_CLASS];

    assign in_if.in_ready = ready_q;
    assign fire    = in_if.in_valid & ready_q;
    assign drop_q  = (state_q == ST_DRAIN);
    assign at_end  = (cnt_q == CNT_END);
    assign first_c = (cnt_q == '0);

    // Ready is low only while reset is applied.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ready_q <= 1'b0;
        else
            ready_q <= 1'b1;
    end

    // Beat counter and drain state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ACCUM;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Classify each accepted beat; end of frame is either in_last or a full count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        good_c  = 1'b0;
        err_c   = 1'b0;
        if (fire) begin
            if (drop_q) begin
                if (in_if.in_last)
                    state_d = ST_ACCUM;
            end else begin
                take = 1'b1;
                if (in_if.in_last || at_end) begin
                    cnt_d  = '0;
                    good_c = in_if.in_last && at_end;
                    err_c  = in_if.in_last != at_end;
                    if (at_end && !in_if.in_last)
                        state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // Beat flags travel alongside the lane pipeline so strobes line up with the scores.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q        <= 1'b0;
            first1_q    <= 1'b0;
            good1_q     <= 1'b0;
            err1_q      <= 1'b0;
            good2_q     <= 1'b0;
            err2_q      <= 1'b0;
            Input_Valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            v1_q        <= take;
            first1_q    <= first_c;
            good1_q     <= good_c;
            err1_q      <= err_c;
            good2_q     <= v1_q & good1_q;
            err2_q      <= v1_q & err1_q;
            Input_Valid <= good2_q;
            frame_err   <= err2_q;
        end
    end

    for (genvar k = 0; k < N_CLASS; k++) begin : g_lane
        score_mac u_mac (
            .clk    (clk),
            .rst    (rst),
            .ld_en  (take),
            .act    (in_if.in_act),
            .w      (in_if.in_w[k]),
            .acc_en (v1_q),
            .first  (first1_q),
            .out_en (good2_q),
            .score  (score[k])
        );
    end

    assign s0 = score[0];
    assign s1 = score[1];
    assign s2 = score[2];
    assign s3 = score[3];
    assign s4 = score[4];
    assign s5 = score[5];
    assign s6 = score[6];
    assign s7 = score[7];
    assign s8 = score[8];
    assign s9 = score[9];

endmodule
